// File: rtl/drone_pkg.sv
// Shared constants and width helpers for the parametrised drone datapath.
// Imported by fluxo_dados_drone_param and updown_sat_counter.
package drone_pkg;

  localparam int W_MODO = 2;

  localparam logic [W_MODO-1:0] MODO_FACIL   = 2'd0;
  localparam logic [W_MODO-1:0] MODO_MEDIO   = 2'd1;
  localparam logic [W_MODO-1:0] MODO_DIFICIL = 2'd2;

  // Bit positions inside controle_vertical / controle_horizontal
  localparam int DIR_UP   = 0;
  localparam int DIR_DOWN = 1;
  localparam int DIR_FWD  = 0;
  localparam int DIR_BACK = 1;

  // Register width able to hold 0..n-1; never narrower than one bit
  function automatic int w_of(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/updown_sat_counter.sv
// Up/down step counter bounded to MIN..MAX, either saturating or wrapping.
// Simultaneous up and down requests cancel; clear returns to RST_VAL.
module updown_sat_counter
  import drone_pkg::*;
#(
  parameter int W       = 4,
  parameter int MIN     = 0,
  parameter int MAX     = 15,
  parameter bit WRAP    = 1'b0,
  parameter int RST_VAL = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] Q_MIN = W'(MIN);
  localparam logic [W-1:0] Q_MAX = W'(MAX);
  localparam logic [W-1:0] Q_RST = W'(RST_VAL);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      q <= Q_RST;
    end else if (en && (up ^ down)) begin
      if (up) begin
        if (q >= Q_MAX) q <= WRAP ? Q_MIN : Q_MAX;
        else            q <= q + 1'b1;
      end else begin
        if (q <= Q_MIN) q <= WRAP ? Q_MAX : Q_MIN;
        else            q <= q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fluxo_dados_drone_param.sv
// Parametrised datapath of the drone obstacle game: position, selectors,
// move timer, obstacle memory and hit counting. Optional macro: DRONE_GRACE_EN.
module fluxo_dados_drone_param
  import drone_pkg::*;
#(
  parameter int MAP_LEN      = 16,
  parameter int LANES        = 4,
  parameter int N_MAPS       = 4,
  parameter int MAX_LIVES    = 5,
  parameter int T_EASY       = 32,
  parameter int T_MED        = 24,
  parameter int T_HARD       = 16,
  parameter int GRACE_CYCLES = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [1:0]                      controle_vertical,
  input  logic [1:0]                      controle_horizontal,
  input  logic                            zera_posicoes,
  input  logic                            reseta_vidas,
  input  logic                            iniciar,
  input  logic                            conta_t,
  input  logic                            zera_t,
  input  logic                            desloca,
  input  logic                            escolhe_modo,
  input  logic                            escolhe_vida,
  input  logic                            escolhe_mapa,
  input  logic                            checa_colisao,
  input  logic                            atualiza,
  input  logic                            map_we,
  input  logic [w_of(N_MAPS)-1:0]         map_sel,
  input  logic [w_of(MAP_LEN)-1:0]        map_addr,
  input  logic [LANES-1:0]                map_data,
  output logic [w_of(MAP_LEN)-1:0]        pos_h,
  output logic [w_of(LANES)-1:0]          pos_v,
  output logic [LANES-1:0]                obstaculos,
  output logic [1:0]                      modo,
  output logic [w_of(MAX_LIVES+1)-1:0]    vidas,
  output logic [w_of(MAX_LIVES+1)-1:0]    colisoes,
  output logic                            hit,
  output logic                            colisao,
  output logic                            timeout,
  output logic                            fim_mapa,
  output logic                            borda_movimento
);

  localparam int W_H   = w_of(MAP_LEN);
  localparam int W_V   = w_of(LANES);
  localparam int W_M   = w_of(N_MAPS);
  localparam int W_L   = w_of(MAX_LIVES + 1);
  localparam int T_MAX = max3(T_EASY, T_MED, T_HARD);
  localparam int W_T   = w_of(T_MAX);

  // Edge detection on the four direction bits
  logic [1:0] prev_v, prev_h;
  logic       up_p, dn_p, fw_p, bk_p;

  assign up_p = controle_vertical[DIR_UP]     & ~prev_v[DIR_UP];
  assign dn_p = controle_vertical[DIR_DOWN]   & ~prev_v[DIR_DOWN];
  assign fw_p = controle_horizontal[DIR_FWD]  & ~prev_h[DIR_FWD];
  assign bk_p = controle_horizontal[DIR_BACK] & ~prev_h[DIR_BACK];
  assign borda_movimento = up_p | dn_p | fw_p | bk_p;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_v <= '0;
      prev_h <= '0;
    end else begin
      prev_v <= controle_vertical;
      prev_h <= controle_horizontal;
    end
  end

  logic [W_M-1:0] mapa;

  updown_sat_counter #(.W(W_H), .MIN(0), .MAX(MAP_LEN-1), .WRAP(1'b0), .RST_VAL(0)) u_pos_h (
    .clock(clock), .reset(reset), .clear(zera_posicoes), .en(desloca),
    .up(fw_p), .down(bk_p), .q(pos_h)
  );

  updown_sat_counter #(.W(W_V), .MIN(0), .MAX(LANES-1), .WRAP(1'b0), .RST_VAL(LANES/2)) u_pos_v (
    .clock(clock), .reset(reset), .clear(zera_posicoes), .en(desloca),
    .up(up_p), .down(dn_p), .q(pos_v)
  );

  updown_sat_counter #(.W(W_MODO), .MIN(0), .MAX(2), .WRAP(1'b0), .RST_VAL(0)) u_modo (
    .clock(clock), .reset(reset), .clear(iniciar), .en(escolhe_modo),
    .up(up_p), .down(dn_p), .q(modo)
  );

  updown_sat_counter #(.W(W_L), .MIN(1), .MAX(MAX_LIVES), .WRAP(1'b0), .RST_VAL(1)) u_vidas (
    .clock(clock), .reset(reset), .clear(reseta_vidas), .en(escolhe_vida),
    .up(up_p), .down(dn_p), .q(vidas)
  );

  updown_sat_counter #(.W(W_M), .MIN(0), .MAX(N_MAPS-1), .WRAP(1'b1), .RST_VAL(0)) u_mapa (
    .clock(clock), .reset(reset), .clear(reseta_vidas), .en(escolhe_mapa),
    .up(up_p), .down(dn_p), .q(mapa)
  );

  // Move timer: the >= compare lets a mid-count switch to a faster mode
  // expire immediately instead of running past the new limit.
  logic [W_T-1:0] timer;
  logic [W_T-1:0] t_lim;

  always_comb begin
    t_lim = W_T'(T_HARD - 1);
    case (modo)
      MODO_FACIL: t_lim = W_T'(T_EASY - 1);
      MODO_MEDIO: t_lim = W_T'(T_MED - 1);
      default:    t_lim = W_T'(T_HARD - 1);
    endcase
  end

  assign timeout = (timer >= t_lim);

  always_ff @(posedge clock) begin
    if (reset || zera_t) timer <= '0;
    else if (conta_t)    timer <= timeout ? '0 : timer + 1'b1;
  end

  // Obstacle memory: not reset, read registered so reads see pre-write data
  logic [LANES-1:0] mem [N_MAPS][MAP_LEN];

  always_ff @(posedge clock) begin
    if (map_we && (int'(map_sel) < N_MAPS) && (int'(map_addr) < MAP_LEN))
      mem[map_sel][map_addr] <= map_data;
    obstaculos <= mem[mapa][pos_h];
  end

  // Hit detection on the rising edge of the qualified collision condition
  logic col_q, col_prev, hit_edge, hit_ok;

  assign col_q    = obstaculos[pos_v] & checa_colisao & atualiza;
  assign hit_edge = col_q & ~col_prev;

`ifdef DRONE_GRACE_EN
  localparam int W_G = w_of(GRACE_CYCLES + 1);
  logic [W_G-1:0] grace;

  assign hit_ok = hit_edge && (grace == '0);

  always_ff @(posedge clock) begin
    if (reset || zera_posicoes) grace <= '0;
    else if (hit_ok)            grace <= W_G'(GRACE_CYCLES);
    else if (grace != '0)       grace <= grace - 1'b1;
  end
`else
  assign hit_ok = hit_edge;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      col_prev <= 1'b0;
      colisoes <= '0;
      hit      <= 1'b0;
    end else begin
      col_prev <= col_q;
      if (zera_posicoes) begin
        colisoes <= '0;
        hit      <= 1'b0;
      end else begin
        hit <= hit_ok;
        if (hit_ok && (colisoes < W_L'(MAX_LIVES)))
          colisoes <= colisoes + 1'b1;
      end
    end
  end

  assign colisao  = (colisoes >= vidas);
  assign fim_mapa = (pos_h == W_H'(MAP_LEN - 1));

endmodule

// File: doc/fluxo_dados_drone_param.md
Name: fluxo_dados_drone_param

Overview:
Parametrised datapath for the drone obstacle game, the successor to the fixed 16x4 datapath.
- Drone position: horizontal over MAP_LEN columns, vertical over LANES lanes.
- Selectors for difficulty mode, lives and map, chosen from N_MAPS maps held in runtime-writable obstacle memory.
- Per-mode move timeout, collision counting, and status flags for the game FSM.
- Sits between the controller FSM (control strobes in, status out) and the board I/O.

Parameters:
MAP_LEN, 16, number of map columns (>=2)
LANES, 4, number of vertical lanes; obstacle word width (>=2)
N_MAPS, 4, number of stored maps (>=1)
MAX_LIVES, 5, maximum selectable lives (>=1)
T_EASY, 32, timeout period in conta_t cycles, mode 0
T_MED, 24, timeout period, mode 1
T_HARD, 16, timeout period, mode 2
GRACE_CYCLES, 8, hit-immunity window (optional feature only)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
controle_vertical  in  2  [0]=up/increment, [1]=down/decrement (level)
controle_horizontal  in  2  [0]=forward, [1]=back (level)
zera_posicoes  in  1  reset positions and collision count
reseta_vidas  in  1  lives<-1, map<-0
iniciar  in  1  mode<-0
conta_t / zera_t  in  1/1  timer enable / synchronous clear (clear wins)
desloca, escolhe_modo, escolhe_vida, escolhe_mapa  in  1 each  apply vertical/horizontal edge to position / mode / lives / map
checa_colisao, atualiza  in  1/1  collision evaluation enable / update strobe
map_we  in  1  obstacle memory write enable
map_sel  in  clog2(N_MAPS)  map to write
map_addr  in  clog2(MAP_LEN)  column to write
map_data  in  LANES  obstacle word, bit i = obstacle in lane i
pos_h  out  clog2(MAP_LEN)  horizontal position
pos_v  out  clog2(LANES)  vertical position
obstaculos  out  LANES  obstacle word of selected map at current pos_h
modo  out  2  0 easy, 1 medium, 2 hard
vidas  out  clog2(MAX_LIVES+1)  selected lives
colisoes  out  clog2(MAX_LIVES+1)  hits counted
hit  out  1  one-cycle pulse per counted hit
colisao, timeout, fim_mapa, borda_movimento  out  1 each  status flags

Behaviour:
- Reset (synchronous): pos_h=0; pos_v=LANES/2; modo=0; vidas=1; map=0; colisoes=0; timer=0; edge registers=0; hit=0. Obstacle memory is not affected by reset; its contents are zero at power-up.
- Edge detection: each control bit passes a one-flop rising-edge detector (pulse = bit & ~prev). borda_movimento = OR of all four pulses.
- Up and down edges in the same cycle cancel: no move, no selector change. The same rule applies to forward/back.
- Position move: with desloca, pos_h/pos_v step +/-1, saturating at 0 and MAP_LEN-1 / LANES-1.
- zera_posicoes has priority over any move.
- Selectors: with escolhe_* and a vertical edge:
  - modo saturates in 0..2;
  - vidas saturates in 1..MAX_LIVES;
  - map wraps modulo N_MAPS.
- Timer: counts while conta_t. timeout is combinationally high while count == T(modo)-1; on that cycle the next count is 0.
- Changing modo mid-count does not clear the timer. If count >= the new T-1, timeout asserts and the timer wraps on the next conta_t.
- Obstacle memory:
  - Read: synchronous, 1-cycle latency; obstaculos reflects pos_h/map of the previous cycle.
  - Write: takes effect at the clock edge.
  - Read-during-write to the same location returns the old data.
- Collision condition: cond = obstaculos[pos_v] & checa_colisao. A hit is counted on the rising edge of (cond & atualiza), so it is registered once per continuous assertion.
- On a hit: hit pulses and colisoes increments, saturating at MAX_LIVES. zera_posicoes in the same cycle wins: count=0, no hit.
- colisao = (colisoes >= vidas), combinational.
- fim_mapa = (pos_h == MAP_LEN-1).

Optional Feature:
Macro DRONE_GRACE_EN.
- Defined: after a counted hit, an immunity counter loads GRACE_CYCLES. While it is nonzero, hits are suppressed (no hit pulse, no increment). The counter is cleared by reset and by zera_posicoes.
- Undefined: no immunity counter exists and every qualifying edge counts. GRACE_CYCLES is then unused.

Decomposition:
- Package drone_pkg:
  - mode encoding constants MODO_FACIL/MEDIO/DIFICIL;
  - direction-bit indices;
  - width helper constants derived with clog2.
- One sub-module, updown_sat_counter, parametrised on width/min/max/wrap. It is used for pos_h, pos_v, modo, vidas and map.
- Edge detectors and the memory stay inline.

Test Plan:
- After reset: pos_v=2 (LANES=4), pos_h=0, vidas=1. Then 20 forward edges with desloca -> pos_h=15, fim_mapa=1, no wrap.
- modo=1, conta_t held high -> timeout high on the 24th count cycle, then count=0. zera_t mid-count -> restart from 0.
- Write map 2 col 3 = 4'b0100, select map 2, move to pos_h=3, pos_v=2, atualiza+checa_colisao held 5 cycles -> exactly one hit, colisoes=1.
- vidas=2, two separated hits -> colisao=1 after the second. A third hit with MAX_LIVES=2 -> colisoes stays 2.
- Simultaneous up+down edges with desloca -> pos_v unchanged. Reset asserted mid-game -> all outputs return to reset values next cycle; memory contents preserved.
- DRONE_GRACE_EN defined, GRACE_CYCLES=8: second hit 3 cycles after the first -> ignored; second hit 10 cycles after the first -> counted.
